serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//  Multi-cycle adder/subtractor: WIDTH-bit operands added DIGIT bits per clock through a ripple
//  slice, with a registered carry between beats. Successor to the single-bit combinational full
//  adder: parametrised width/digit, subtract mode, carry-in, overflow flag, valid/ready on both
//  sides. Used where area matters more than latency (datapath accumulators, test ALUs).
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be >= 1 and a multiple of DIGIT
//  DIGIT  1  bits processed per beat; BEATS = WIDTH/DIGIT; DIGIT == WIDTH -> single-beat adder
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  in_valid  in   1      operand request
//  in_ready  out  1      block idle, can accept operands
//  a         in   WIDTH  operand A
//  b         in   WIDTH  operand B
//  cin       in   1      carry-in (borrow-in when sub=1)
//  sub       in   1      0: a+b+cin; 1: a-b-cin
//  out_valid out  1      result available
//  out_ready in   1      consumer accepts result
//  sum       out  WIDTH  result, modulo 2^WIDTH
//  cout      out  1      raw carry out of MSB (for sub: 1 = no borrow)
//  overflow  out  1      two's-complement overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; sum=0, cout=0, overflow=0, out_valid=0,
//    in_ready=0 while rst high, 1 from first cycle after release. In-flight operation discarded.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: in_ready=1. Edge with in_valid=1: latch a, (sub ? ~b : b), carry=cin^sub,
//          beat count=0, go RUN. Operand/mode inputs ignored outside this edge.
//    RUN : each edge adds DIGIT LSBs of A, B and carry; result digit shifted into sum from the MSB
//          end, operands shifted right DIGIT, carry register updated. On beat BEATS-1 also capture
//          carry into MSB; go DONE.
//    DONE: out_valid=1; sum/cout/overflow stable. Edge with out_ready=1 -> IDLE.
//  - Latency: in_valid accepted at edge k -> out_valid high in cycle after edge k+BEATS.
//    Throughput: one op per BEATS+2 cycles with out_ready held high.
//  - in_ready=0 in RUN/DONE; in_valid there is ignored (no queueing).
//  - out_valid held with all result bits constant until handshake; no drop, no overwrite.
//  - sum/cout/overflow retain last result in IDLE/RUN (checked only when out_valid=1).
//  - Widths: internal digit sum is DIGIT+1 bits; carry is 1 bit; no truncation except the
//    defined modulo on sum. Beat counter width $clog2(BEATS+1).
//  - BEATS==1: RUN lasts one edge; behaviour otherwise identical.
//  - rst asserted in any state: immediate return to IDLE, out_valid drops asynchronously.
// STRUCTURE
//  - Package serial_adder_pkg: state encoding localparams (IDLE/RUN/DONE), BEATS helper function.
//  - Sub-module adder_slice #(DIGIT): combinational ripple of DIGIT full-adder cells;
//    ports a_d, b_d, c_in -> s_d, c_out, c_msb (carry into top bit). Top holds FSM, shift regs.
//  - Elaboration-time check: WIDTH % DIGIT != 0 -> $error.
// TESTING
//  1. WIDTH=1,DIGIT=1: all 8 {a,b,cin}, sub=0 -> sum=a^b^cin, cout=majority(a,b,cin), each 1-beat.
//  2. WIDTH=8,DIGIT=1: a=7F,b=01,cin=0,sub=0 -> sum=80,cout=0,overflow=1, out_valid 8 cycles
//     after accept edge.
//  3. WIDTH=8,DIGIT=1: a=05,b=07,cin=0,sub=1 -> sum=FE,cout=0,overflow=0; a=80,b=01,sub=1 ->
//     sum=7F,cout=1,overflow=1.
//  4. WIDTH=8,DIGIT=4: a=FF,b=01,cin=1 -> sum=01,cout=1,overflow=0, out_valid after 2 beats.
//  5. Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_valid/sum held,
//     in_ready=0, no new op accepted; out_ready=1 -> IDLE, next op accepted.
//  6. rst pulse mid-RUN (beat 3 of 8) -> out_valid/sum/cout/overflow 0 immediately, IDLE after
//     release; next op a=12,b=34 -> sum=46 correct.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// The state type and the beat-count helper are used by the top-level FSM.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of beats needed to process a full operand; guards against DIGIT == 0.
    function automatic int calc_beats(input int width, input int digit);
        return (digit > 0) ? (width / digit) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The master side supplies operands and accepts results; the slave side is the adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );

endinterface

// File: rtl/serial_adder_slice.sv
// Combinational ripple of DIGIT full-adder cells, processing one digit per beat.
// c_msb is the carry entering the top cell, which the top module uses for overflow.
module adder_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             c_in,
    output logic [DIGIT-1:0] s_d,
    output logic             c_out,
    output logic             c_msb
);

    always_comb begin
        logic carry;
        carry = c_in;
        c_msb = c_in;
        s_d   = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_msb = carry;
            end
            s_d[i] = a_d[i] ^ b_d[i] ^ carry;
            carry  = (a_d[i] & b_d[i]) | (carry & (a_d[i] ^ b_d[i]));
        end
        c_out = carry;
    end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock
// through adder_slice, with a registered carry between beats and valid/ready on both sides.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int BEATS = calc_beats(WIDTH, DIGIT);
    localparam int CNT_W = $clog2(BEATS + 1);

    generate
        if (WIDTH < 1 || DIGIT < 1) begin : g_bad_size
            $error("serial_adder: WIDTH and DIGIT must be >= 1");
        end else if (WIDTH % DIGIT != 0) begin : g_bad_ratio
            $error("serial_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CNT_W-1:0] beat_cnt;

    logic [DIGIT-1:0]       s_d;
    logic                   c_out;
    logic                   c_msb;
    logic [WIDTH+DIGIT-1:0] acc_ext;
    logic                   last_beat;

    // New digits enter at the MSB end, so after BEATS beats the LSB digit sits at bit 0.
    assign acc_ext   = {s_d, acc};
    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

    adder_slice #(
        .DIGIT(DIGIT)
    ) u_slice (
        .a_d   (a_sh[DIGIT-1:0]),
        .b_d   (b_sh[DIGIT-1:0]),
        .c_in  (carry),
        .s_d   (s_d),
        .c_out (c_out),
        .c_msb (c_msb)
    );

    // Subtraction is folded in at accept time as a + ~b + 1, with cin acting as a borrow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.cout      <= 1'b0;
            bus.overflow  <= 1'b0;
            a_sh          <= '0;
            b_sh          <= '0;
            acc           <= '0;
            carry         <= 1'b0;
            beat_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_ready && bus.in_valid) begin
                        a_sh         <= bus.a;
                        b_sh         <= bus.sub ? ~bus.b : bus.b;
                        carry        <= bus.cin ^ bus.sub;
                        beat_cnt     <= '0;
                        bus.in_ready <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    a_sh     <= a_sh >> DIGIT;
                    b_sh     <= b_sh >> DIGIT;
                    carry    <= c_out;
                    acc      <= acc_ext[WIDTH+DIGIT-1:DIGIT];
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    if (last_beat) begin
                        bus.sum       <= acc_ext[WIDTH+DIGIT-1:DIGIT];
                        bus.cout      <= c_out;
                        bus.overflow  <= c_msb ^ c_out;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    // Result is frozen here until the consumer takes it.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
